serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial add/subtract engine: sequences one full_adder_structural cell over WIDTH
//  clock cycles to add or subtract two WIDTH-bit operands, LSB first.
//  Carry is kept in a flip-flop between bits. A start/ready/done handshake lets a
//  host share the single 1-bit adder cell instead of using a WIDTH-bit ripple adder.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2); bit counter is $clog2(WIDTH) wide
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request; sampled only when ready=1
//  sub     in   1      0: a+b, 1: a-b; sampled with start
//  a       in   WIDTH  operand A; sampled with start
//  b       in   WIDTH  operand B; sampled with start
//  ready   out  1      1 in IDLE: a new start is accepted
//  busy    out  1      1 in RUN or DONE (equals ~ready)
//  done    out  1      one-cycle pulse: sum/cout/ovf just updated
//  sum     out  WIDTH  result, held until the next operation completes
//  cout    out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf     out  1      two's-complement overflow: carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, counter=0, carry FF=0, shift regs=0;
//   sum=0, cout=0, ovf=0, done=0, ready=1, busy=0.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: on the edge where start=1, load a_sr<=a, b_sr<=b^{WIDTH{sub}}, carry<=sub,
//   cnt<=0, state<=RUN. start=0: stay IDLE, no register changes.
//  RUN: full adder inputs a_sr[0], b_sr[0], carry. Each edge: carry<=fa cout,
//   res_sr<={fa sum, res_sr[WIDTH-1:1]}, a_sr/b_sr shift right 1, cnt<=cnt+1.
//   On the edge with cnt==WIDTH-1 (last bit): sum<={fa sum, res_sr[WIDTH-1:1]},
//   cout<=fa cout, ovf<=carry^fa cout (carry = carry into MSB), state<=DONE.
//  DONE: done=1 for exactly this cycle; next edge state<=IDLE.
//  done/ready/busy are decoded from state (glitch-free registered state).
//  Latency: start sampled at edge 0 -> sum valid and done=1 after edge WIDTH,
//   done drops after edge WIDTH+1. Throughput: one operation per WIDTH+2 cycles.
//  start while busy=1 is ignored. It is neither queued nor able to corrupt operands.
//   a/b/sub may change freely after the accepting edge.
//  sum/cout/ovf change only on the last-bit edge (and reset). Between operations
//   they hold the last result.
//  Wrap-around: result is modulo 2^WIDTH; cout/ovf report the carry/overflow.
//  Reset mid-operation: aborts immediately to the reset state. No done pulse.
//   The previous result is lost (sum=0).
//  No combinational path from any input to any output.
// TESTING (WIDTH=8)
//  add 200+100 (C8+64) -> done after 8 cycles; sum=0x2C, cout=1, ovf=0
//  add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1; then 0xFF+0x01 -> sum=0x00, cout=1, ovf=0
//  sub 5-7 -> sum=0xFE, cout=0 (borrow), ovf=0; sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1
//  start pulse with a=0x11 while busy, 3 cycles into 0x10+0x20 -> ignored;
//   sum=0x30, exactly one done pulse
//  rst_n low for 1 cycle at RUN bit 4 -> all outputs 0, ready=1, no done;
//   next 0x03+0x04 -> sum=0x07
//  back-to-back: hold start=1 continuously -> a new op is accepted only in IDLE;
//   done pulses exactly WIDTH+2 cycles apart

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine. One full-adder cell is reused for WIDTH cycles, LSB first.
// The carry is held in a flop between bits, and a start/ready/done handshake sequences each operation.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    // Only WIDTH-1 partial bits are stored; the final bit comes straight from the adder.
    logic [WIDTH-2:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_sum;
    logic fa_cout;
    logic last_bit;

    assign fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_cout  = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d  = fa_cout;
                res_sr_d = {fa_sum, res_sr_q[WIDTH-2:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d   = {fa_sum, res_sr_q};
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the shift registers are plain flops, so they take the reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule
